// File: rtl/fpmul_iter_pkg.sv
// fpmul_iter_pkg: FP32 field layout, constants, FSM states and pack/unpack helpers
package fpmul_iter_pkg;
   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [22:0] man;
   } fp32_t;
   localparam int FP32_BIAS = 127;
   localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
   localparam logic [7:0] FP32_INF_EXP = 8'hFF;
   typedef enum logic [1:0] {IDLE, MUL, NORM} fpmul_state_t;
   function automatic fp32_t f32unpack(input logic [31:0] w);
      return fp32_t'(w);
   endfunction
   function automatic logic [31:0] f32pack(input logic s, input logic [7:0] e, input logic [22:0] m);
      return {s, e, m};
   endfunction
endpackage

// File: rtl/fpmul_iter_if.sv
// fpmul_iter_if: request/response bundle of the iterative FP32 multiplier
interface fpmul_iter_if;
   logic        start, rm, busy, done;
   logic [31:0] a, b, result;
   modport master(output start, rm, a, b, input busy, done, result);
   modport slave(input start, rm, a, b, output busy, done, result);
endinterface

// File: rtl/fpmul_iter_norm_round.sv
// fpmul_iter_norm_round: normalize a 48-bit mantissa product and round RZ/RNE;
// exp is the normalized exponent, the caller adds the rounding carry
module fpmul_iter_norm_round #(parameter int EXP_W = 10) (
   input  logic [47:0]      prod,
   input  logic [EXP_W-1:0] exp_in,
   input  logic             rm,
   output logic [EXP_W-1:0] exp,
   output logic [22:0]      man,
   output logic             carry
);
   logic        hi, guard, sticky;
   logic [22:0] m;
   always_comb begin
      hi = prod[47];
      m = hi ? prod[46:24] : prod[45:23];
      guard = hi ? prod[23] : prod[22];
      sticky = hi ? |prod[22:0] : |prod[21:0];
      {carry, man} = {1'b0, m} + 24'(rm & guard & (sticky | m[0]));
      exp = exp_in + EXP_W'(hi);
   end
endmodule

// File: rtl/fpmul_iter.sv
// fpmul_iter: iterative FP32 shift-add multiplier, start/busy/done handshake.
// FPMUL_SPECIALS_EN adds zero/inf/NaN handling and exponent range clamping.
module fpmul_iter
   import fpmul_iter_pkg::*;
#(parameter int BITS_PER_CYCLE = 2) (
   input logic         clk,
   input logic         reset,
   fpmul_iter_if.slave bus
);
   localparam int ITER = 24 / BITS_PER_CYCLE;
`ifdef FPMUL_SPECIALS_EN
   localparam int EW = 10;
`else
   localparam int EW = 8;
`endif
   fpmul_state_t  state;
   logic [4:0]    cnt;
   logic [47:0]   acc, mcand, part;
   logic [23:0]   mplier;
   logic          sign, rm_q, done_q, n_carry;
   logic [31:0]   result_q, res_n;
   logic [EW-1:0] exp_q, n_exp, e_fin;
   logic [22:0]   n_man;
   fp32_t         fa, fb;
   assign fa = f32unpack(bus.a);
   assign fb = f32unpack(bus.b);
   assign bus.busy = state != IDLE;
   assign bus.done = done_q;
   assign bus.result = result_q;
   // multiplicand shifts left and multiplier right so each step sees its low bits
   always_comb begin
      part = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) part = part + (mplier[j] ? mcand << j : 48'd0);
   end
   fpmul_iter_norm_round #(.EXP_W(EW)) u_nr (
      .prod(acc), .exp_in(exp_q), .rm(rm_q), .exp(n_exp), .man(n_man), .carry(n_carry)
   );
   assign e_fin = n_exp + EW'(n_carry);
`ifdef FPMUL_SPECIALS_EN
   logic nan_q, inf_q, zero_q, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   assign a_zero = fa.exp == 8'h00;
   assign b_zero = fb.exp == 8'h00;
   assign a_inf = fa.exp == FP32_INF_EXP && fa.man == '0;
   assign b_inf = fb.exp == FP32_INF_EXP && fb.man == '0;
   assign a_nan = fa.exp == FP32_INF_EXP && fa.man != '0;
   assign b_nan = fb.exp == FP32_INF_EXP && fb.man != '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         nan_q <= 1'b0;
         inf_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         nan_q <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
         inf_q <= a_inf | b_inf;
         zero_q <= a_zero | b_zero;
      end
   end
   assign res_n = nan_q ? FP32_QNAN :
                  inf_q ? f32pack(sign, FP32_INF_EXP, '0) :
                  zero_q ? f32pack(sign, '0, '0) :
                  (!e_fin[9] && e_fin >= 10'd255) ? f32pack(sign, FP32_INF_EXP, '0) :
                  (e_fin[9] || e_fin == '0) ? f32pack(sign, '0, '0) :
                  f32pack(sign, e_fin[7:0], n_man);
`else
   assign res_n = f32pack(sign, e_fin[7:0], n_man);
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         sign <= 1'b0;
         rm_q <= 1'b0;
         exp_q <= '0;
         done_q <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state <= MUL;
               cnt <= '0;
               acc <= '0;
               mcand <= {24'd0, 1'b1, fa.man};
               mplier <= {1'b1, fb.man};
               sign <= fa.sign ^ fb.sign;
               rm_q <= bus.rm;
               exp_q <= EW'(fa.exp) + EW'(fb.exp) - EW'(FP32_BIAS);
            end
            MUL: begin
               acc <= acc + part;
               mcand <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
               cnt <= cnt + 5'd1;
               if (cnt == 5'(ITER - 1)) state <= NORM;
            end
            NORM: begin
               done_q <= 1'b1;
               result_q <= res_n;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpmul_iter.sv
// tb_fpmul_iter: directed handshake/rounding tests plus a BITS_PER_CYCLE sweep against a reference model
module tb_fpmul_iter;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   fpmul_iter_if bus();
   fpmul_iter dut(.clk(clk), .reset(reset), .bus(bus));
   int checks = 0, errors = 0;
   logic [31:0] sb[$];
   logic [31:0] sw_q[$];
   localparam int BPC[3] = '{1, 4, 24};
   logic        sw_start = 1'b0, sw_rm = 1'b0;
   logic [31:0] sw_a = '0, sw_b = '0;
   logic [2:0]  sw_done;
   logic [31:0] sw_res[3];
   for (genvar g = 0; g < 3; g++) begin : g_sw
      fpmul_iter_if sif();
      assign sif.start = sw_start;
      assign sif.rm = sw_rm;
      assign sif.a = sw_a;
      assign sif.b = sw_b;
      assign sw_done[g] = sif.done;
      assign sw_res[g] = sif.result;
      fpmul_iter #(.BITS_PER_CYCLE(BPC[g])) u(.clk(clk), .reset(reset), .bus(sif));
   end
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic rm);
      logic [47:0] p, q, rem, half;
      logic [9:0]  e;
      int          sh;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      sh = p[47] ? 24 : 23;
      q = p >> sh;
      rem = p - (q << sh);
      half = 48'd1 << (sh - 1);
      if (rm && (rem > half || (rem == half && q[0]))) q = q + 48'd1;
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'd0, p[47]};
      if (q[24]) begin
         q = q >> 1;
         e = e + 10'd1;
      end
      return {a[31] ^ b[31], e[7:0], q[22:0]};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic [31:0] e);
      bus.a = a;
      bus.b = b;
      bus.rm = rm;
      bus.start = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int lat);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.done && n < 40);
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check(tag, bus.result, sb.size() > 0 ? sb.pop_front() : 32'hxxxxxxxx);
   endtask
   initial begin
      int extra;
      logic [31:0] ra, rb;
      logic rr;
      bus.start = 1'b0;
      bus.rm = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_result", bus.result, 32'h0);
      reset = 1'b0;
      drive(32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000);
      wait_done("t1", 13);
      drive(32'h3FC00001, 32'h3FC00000, 1'b0, 32'h40100000);
      wait_done("t2_rz", 13);
      drive(32'h3FC00001, 32'h3FC00000, 1'b1, 32'h40100001);
      wait_done("t2_rne", 13);
      // start held through 8 busy cycles must be ignored
      drive(32'hC0000000, 32'h40400000, 1'b1, 32'hC0C00000);
      bus.start = 1'b1;
      bus.a = 32'h3F800000;
      repeat (8) @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("t3", 5);
      extra = 0;
      repeat (20) begin
         @(posedge clk); #1;
         extra += int'(bus.done);
      end
      check("t3_single_done", extra, 0);
      drive(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("t4_busy", {31'd0, bus.busy}, 32'd0);
      check("t4_done", {31'd0, bus.done}, 32'd0);
      check("t4_result", bus.result, 32'h0);
      reset = 1'b0;
      sb.delete();
      extra = 0;
      repeat (15) begin
         @(posedge clk); #1;
         extra += int'(bus.done);
      end
      check("t4_no_done", extra, 0);
      drive(32'h40400000, 32'h40400000, 1'b1, 32'h41100000);
      wait_done("t4_fresh", 13);
      drive(32'h40000000, 32'h3F800000, 1'b1, 32'h40000000);
      wait_done("t5_first", 13);
      drive(32'h40000000, 32'h40000000, 1'b1, 32'h40800000);
      wait_done("t5_b2b", 13);
`ifdef FPMUL_SPECIALS_EN
      drive(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000);
      wait_done("t6_inf_zero", 13);
      drive(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000);
      wait_done("t6_overflow", 13);
      drive(32'h80000000, 32'h3F800000, 1'b1, 32'h80000000);
      wait_done("t6_neg_zero", 13);
`endif
      for (int t = 0; t < 8; t++) begin
         ra = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
         rb = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
         rr = 1'($urandom);
         sw_a = ra;
         sw_b = rb;
         sw_rm = rr;
         sw_start = 1'b1;
         sw_q.push_back(ref_mul(ra, rb, rr));
         @(posedge clk); #1;
         sw_start = 1'b0;
         for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
               if (c == 24 / BPC[k] + 1) begin
                  check($sformatf("t7_done_bpc%0d", BPC[k]), {31'd0, sw_done[k]}, 32'd1);
                  check($sformatf("t7_result_bpc%0d", BPC[k]), sw_res[k], sw_q[0]);
               end
            end
         end
         void'(sw_q.pop_front());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
